// File: rtl/store_forward_responder.sv
// rtl/store_forward_responder.sv - returns a retired result to the load/store queue,
// either from the retire ports in flight or from the per-ID result buffer.

package taiga_config;
  localparam int MAX_IDS = 8;
endpackage

package taiga_types;
  import taiga_config::*;
  typedef logic [$clog2(MAX_IDS)-1:0] id_t;
endpackage

interface writeback_store_interface;
  import taiga_types::*;
  logic        waiting;
  id_t         id_needed;
  logic        ack;
  logic        id_done;
  logic [31:0] data;

  modport wb (input waiting, id_needed, ack, output id_done, data);
  modport ls (output waiting, id_needed, ack, input id_done, data);
endinterface

module store_forward_responder
  import taiga_config::*;
  import taiga_types::*;
#(
  parameter int NUM_RETIRE_PORTS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        gc_issue_flush,
  writeback_store_interface.wb        wb_store,
  input  logic                        id_alloc,
  input  id_t                         id_alloc_id,
  input  logic [NUM_RETIRE_PORTS-1:0] retire_valid,
  input  id_t                         retire_id   [NUM_RETIRE_PORTS],
  input  logic [31:0]                 retire_data [NUM_RETIRE_PORTS]
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic        id_done_r;
  logic [31:0] data_r;
  id_t         needed_id_r;
  logic [MAX_IDS-1:0] avail;
  logic [31:0] buffer [MAX_IDS];

  id_t         cmp_id;
  logic        hit;
  logic [31:0] hit_data;

  // Scan from the highest port down so the lowest matching index is the one left standing.
  always_comb begin
    cmp_id   = (state == WAIT) ? needed_id_r : wb_store.id_needed;
    hit      = 1'b0;
    hit_data = '0;
    for (int p = NUM_RETIRE_PORTS - 1; p >= 0; p--) begin
      if (retire_valid[p] && (retire_id[p] == cmp_id)) begin
        hit      = 1'b1;
        hit_data = retire_data[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_RETIRE_PORTS; p++) begin
      if (retire_valid[p])
        buffer[retire_id[p]] <= retire_data[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      id_done_r   <= 1'b0;
      data_r      <= '0;
      needed_id_r <= '0;
      avail       <= '0;
    end else begin
      for (int p = 0; p < NUM_RETIRE_PORTS; p++) begin
        if (retire_valid[p])
          avail[retire_id[p]] <= 1'b1;
      end
      // Placed after the retire loop so a same-cycle allocation of the ID clears it.
      if (id_alloc)
        avail[id_alloc_id] <= 1'b0;

      if (gc_issue_flush) begin
        state     <= IDLE;
        id_done_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (wb_store.waiting) begin
              if (hit) begin
                data_r    <= hit_data;
                id_done_r <= 1'b1;
                state     <= DONE;
              end else if (avail[wb_store.id_needed]) begin
                data_r    <= buffer[wb_store.id_needed];
                id_done_r <= 1'b1;
                state     <= DONE;
              end else begin
                needed_id_r <= wb_store.id_needed;
                state       <= WAIT;
              end
            end
          end
          WAIT: begin
            if (hit) begin
              data_r    <= hit_data;
              id_done_r <= 1'b1;
              state     <= DONE;
            end
          end
          DONE: begin
            if (wb_store.ack) begin
              id_done_r <= 1'b0;
              state     <= IDLE;
            end
          end
          default: begin
            id_done_r <= 1'b0;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

  assign wb_store.id_done = id_done_r;
  assign wb_store.data    = data_r;

endmodule

// File: tb/tb_store_forward_responder.sv
// tb/tb_store_forward_responder.sv - directed vector bench for store_forward_responder.

module tb_store_forward_responder;
  import taiga_types::*;

  localparam int NP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          gc_issue_flush;
  logic          id_alloc;
  id_t           id_alloc_id;
  logic [NP-1:0] retire_valid;
  id_t           retire_id   [NP];
  logic [31:0]   retire_data [NP];

  writeback_store_interface wb_if ();

  store_forward_responder #(.NUM_RETIRE_PORTS(NP)) dut (
    .clk            (clk),
    .rst            (rst),
    .gc_issue_flush (gc_issue_flush),
    .wb_store       (wb_if),
    .id_alloc       (id_alloc),
    .id_alloc_id    (id_alloc_id),
    .retire_valid   (retire_valid),
    .retire_id      (retire_id),
    .retire_data    (retire_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush, waiting;
    logic [2:0]  need;
    logic        ack, alloc;
    logic [2:0]  aid;
    logic [1:0]  rv;
    logic [2:0]  rid0;
    logic [31:0] rd0;
    logic [2:0]  rid1;
    logic [31:0] rd1;
    logic        exp_done;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(logic r, logic f, logic w, logic [2:0] nd, logic a,
                              logic al, logic [2:0] aid, logic [1:0] rv,
                              logic [2:0] i0, logic [31:0] d0, logic [2:0] i1, logic [31:0] d1,
                              logic ed, logic [31:0] edat);
    vec_t v;
    v.rst = r; v.flush = f; v.waiting = w; v.need = nd; v.ack = a;
    v.alloc = al; v.aid = aid; v.rv = rv;
    v.rid0 = i0; v.rd0 = d0; v.rid1 = i1; v.rd1 = d1;
    v.exp_done = ed; v.exp_data = edat;
    vecs.push_back(v);
  endfunction

  task automatic drive(vec_t v);
    rst            = v.rst;
    gc_issue_flush = v.flush;
    wb_if.waiting  = v.waiting;
    wb_if.id_needed = v.need;
    wb_if.ack      = v.ack;
    id_alloc       = v.alloc;
    id_alloc_id    = v.aid;
    retire_valid   = v.rv;
    retire_id[0]   = v.rid0;
    retire_data[0] = v.rd0;
    retire_id[1]   = v.rid1;
    retire_data[1] = v.rd1;
  endtask

  task automatic check(string name, logic ed, logic [31:0] edat);
    checks++;
    if (wb_if.id_done !== ed) begin
      errors++;
      $display("FAIL %s id_done: got %b expected %b", name, wb_if.id_done, ed);
    end
    checks++;
    if (wb_if.data !== edat) begin
      errors++;
      $display("FAIL %s data: got %h expected %h", name, wb_if.data, edat);
    end
  endtask

  task automatic step(vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
  endtask

  vec_t idle_v;

  initial begin
    //  rst f w nd ack al aid rv    id0 d0            id1 d1            done data
    add(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'h0);          // 0 reset
    add(0, 0, 0, 0, 0, 0, 0, 2'b01, 3, 32'hDEADBEEF,  0, 32'h0,         0, 32'h0);          // 1 retire 3
    add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'h0);
    add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'h0);
    add(0, 0, 1, 3, 0, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         1, 32'hDEADBEEF);   // 4 buffer hit
    add(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'hDEADBEEF);   // 5 ack
    add(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'hDEADBEEF);   // 6 stray ack
    add(0, 0, 1, 5, 0, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'hDEADBEEF);   // 7 -> WAIT
    add(0, 0, 1, 5, 0, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'hDEADBEEF);
    add(0, 0, 1, 5, 0, 0, 0, 2'b10, 0, 32'h0,         5, 32'h12345678,  1, 32'h12345678);   // 9 port1 retire
    add(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'h12345678);
    add(0, 0, 0, 0, 0, 0, 0, 2'b01, 2, 32'h1,         0, 32'h0,         0, 32'h12345678);   // 11 stale id 2
    add(0, 0, 1, 2, 0, 0, 0, 2'b01, 2, 32'h2,         0, 32'h0,         1, 32'h2);          // 12 port beats buffer
    add(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'h2);
    add(0, 0, 1, 6, 0, 0, 0, 2'b11, 6, 32'hAAAA,      6, 32'hBBBB,      1, 32'hAAAA);       // 14 lowest port wins
    add(0, 0, 1, 6, 0, 0, 0, 2'b11, 6, 32'hCCCC,      6, 32'hDDDD,      1, 32'hAAAA);       // 15 no retrigger
    add(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'hAAAA);
    add(0, 0, 0, 0, 0, 1, 4, 2'b01, 4, 32'h44,        0, 32'h0,         0, 32'hAAAA);       // 17 alloc+retire 4
    add(0, 0, 1, 4, 0, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'hAAAA);       // 18 -> WAIT
    add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'hAAAA);
    add(0, 0, 0, 0, 0, 0, 0, 2'b01, 4, 32'h45,        0, 32'h0,         1, 32'h45);
    add(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'h45);
    add(0, 0, 1, 5, 0, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         1, 32'h12345678);   // 22 buffer id 5
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 0, 0, 0, 0, 2'b01, 5, 32'hF0F0,    0, 32'h0,         1, 32'h12345678);   // hold, no ack
    add(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'h12345678);
    add(0, 0, 1, 7, 0, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'h12345678);   // 29 -> WAIT
    add(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'h12345678);   // 30 flush
    add(0, 0, 0, 0, 0, 0, 0, 2'b01, 7, 32'h77,        0, 32'h0,         0, 32'h12345678);   // 31 idle ignores
    add(0, 0, 1, 7, 0, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         1, 32'h77);
    add(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'h77);         // 33 flush in DONE
    add(0, 0, 1, 1, 0, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'h77);         // 34 -> WAIT
    add(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'h0);          // 35 reset mid-WAIT
    add(0, 0, 1, 3, 0, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'h0);          // 36 avail cleared
    add(0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 32'h0,         3, 32'h33,        1, 32'h33);
    add(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'h33);
    add(1, 1, 1, 3, 0, 1, 2, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'h0);          // 39 reset priority
    add(1, 0, 0, 0, 0, 0, 0, 2'b01, 6, 32'h66,        0, 32'h0,         0, 32'h0);          // 40 reset beats retire
    add(0, 0, 1, 6, 0, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'h0);          // 41 -> WAIT
    add(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0,         0, 32'h0,         0, 32'h0);

    idle_v = vecs[2];
    drive(idle_v);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
      check($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_data);
    end

    // Late retire: WAIT must hold quiet, then respond exactly one cycle after the retire.
    begin
      vec_t v;
      int   lat;
      v = idle_v;
      v.waiting = 1'b1;
      v.need = 3'd0;
      step(v);
      check("late_wait_enter", 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
        step(idle_v);
        check($sformatf("late_wait_hold%0d", i), 1'b0, 32'h0);
      end
      v = idle_v;
      v.rv = 2'b10;
      v.rid1 = 3'd0;
      v.rd1 = 32'h00C0FFEE;
      step(v);
      lat = 1;
      while (wb_if.id_done !== 1'b1 && lat < 10) begin
        step(idle_v);
        lat++;
      end
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL late_latency: got %0d cycles expected 1", lat);
      end
      check("late_data", 1'b1, 32'h00C0FFEE);
      v = idle_v;
      v.ack = 1'b1;
      step(v);
      check("late_ack", 1'b0, 32'h00C0FFEE);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_forward_responder.md
STORE_FORWARD_RESPONDER -- requirements
Module: store_forward_responder

Interface
REQ-001 SHALL have parameter NUM_RETIRE_PORTS, default 2, number of writeback retire ports observed.
REQ-002 SHALL use MAX_IDS from taiga_config and id_t from taiga_types; id width = $clog2(MAX_IDS).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port gc_issue_flush  input  1  global issue flush.
REQ-006 SHALL have port wb_store  writeback_store_interface.wb  -  responder end of the store-forwarding interface.
REQ-007 SHALL use wb_store.waiting  input  1  the load/store queue requests forwarded data.
REQ-008 SHALL use wb_store.id_needed  input  id_t  the ID whose result is requested.
REQ-009 SHALL use wb_store.ack  input  1  the forwarded store was consumed.
REQ-010 SHALL drive wb_store.id_done  output  1  forwarded data is valid.
REQ-011 SHALL drive wb_store.data  output  32  forwarded store data.
REQ-012 SHALL have port id_alloc  input  1  a new ID is issued this cycle.
REQ-013 SHALL have port id_alloc_id  input  id_t  the newly issued ID.
REQ-014 SHALL have port retire_valid  input  [NUM_RETIRE_PORTS]  per-port retire strobe.
REQ-015 SHALL have port retire_id  input  id_t[NUM_RETIRE_PORTS]  per-port retiring ID.
REQ-016 SHALL have port retire_data  input  32[NUM_RETIRE_PORTS]  per-port result data.

Function
REQ-017 SHALL hold a result buffer of MAX_IDS x 32 bits; each retire_valid[p] writes retire_data[p] at retire_id[p].
REQ-018 SHALL keep one avail bit per ID; a retire sets avail[retire_id].
REQ-019 SHALL clear avail[id_alloc_id] on id_alloc; if the same ID is retired in the same cycle, clear wins.
REQ-020 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-021 IDLE, waiting=1, any retire port matches id_needed: SHALL capture that port's retire_data and go to DONE; if several ports match, the lowest index wins.
REQ-022 IDLE, waiting=1, no port match, avail[id_needed]=1: SHALL capture buffer[id_needed] and go to DONE.
REQ-023 IDLE, waiting=1, no match and no avail: SHALL latch id_needed into needed_id_r and go to WAIT.
REQ-024 WAIT: SHALL compare retire ports against needed_id_r; on a match, capture per REQ-021 and go to DONE; otherwise stay in WAIT.
REQ-025 DONE: SHALL hold id_done=1 and data stable until ack=1, then go to IDLE in the next cycle.
REQ-026 SHALL not re-trigger in DONE even if waiting is still high in the first DONE cycle.
REQ-027 id_done SHALL be registered: 1 cycle after the capture condition, 0 in IDLE and WAIT.
REQ-028 Minimum latency: waiting with an available or retiring ID gives id_done on the next cycle.
REQ-029 gc_issue_flush in any state SHALL force IDLE and id_done=0 next cycle; avail and buffer are retained.
REQ-030 ack outside DONE SHALL be ignored.
REQ-031 data SHALL change only on capture.

Reset
REQ-032 rst SHALL set state=IDLE, id_done=0, data=0, needed_id_r=0, all avail=0.
REQ-033 rst SHALL take priority over gc_issue_flush, retire and alloc in the same cycle.
REQ-034 Buffer contents SHALL need no reset.

Verification
REQ-035 Retire id 3 data 0xDEADBEEF; two cycles later waiting=1, id_needed=3 -> id_done=1 next cycle, data=0xDEADBEEF; ack -> id_done=0 next cycle.
REQ-036 waiting=1, id_needed=5 not avail -> WAIT; retire id 5 data 0x12345678 on port 1 in cycle 4 -> id_done=1 in cycle 5, data=0x12345678.
REQ-037 Same cycle: waiting=1, id_needed=2 with stale avail data 0x1, and port 0 retires id 2 with 0x2 -> data=0x2.
REQ-038 Alloc id 4 and retire id 4 in the same cycle, then waiting for id 4 -> WAIT, no id_done until the next retire of id 4.
REQ-039 In DONE, hold ack=0 for 5 cycles -> id_done and data stable; gc_issue_flush in WAIT -> IDLE, id_done stays 0.
REQ-040 rst mid-WAIT -> id_done=0, avail cleared; waiting for a previously retired id -> enters WAIT.
